// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the UART TX path.
// The master side is the requester/UART environment; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int REQUESTERS = 4
);
  logic [REQUESTERS-1:0]   req_valid;
  logic [8*REQUESTERS-1:0] req_data;
  logic [REQUESTERS-1:0]   req_last;
  logic [REQUESTERS-1:0]   req_ready;
  logic                    tx_valid;
  logic [7:0]              tx_data;
  logic                    tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte interface between several
// byte streams. The owner keeps the transmitter until packet end, a burst
// limit or an idle timeout, so packets never interleave on the serial line.
module uart_tx_arbiter #(
  parameter  int REQUESTERS   = 4,
  parameter  int MAX_BURST    = 16,
  parameter  int IDLE_TIMEOUT = 255,
  localparam int OW           = $clog2(REQUESTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  uart_tx_arbiter_if.slave      bus,
  output logic [REQUESTERS-1:0] grant,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  typedef enum logic {
    IDLE,
    TRANSFER
  } state_t;

  state_t          state;
  logic [OW-1:0]   last_owner;
  logic [7:0]      burst_cnt;
  logic [7:0]      idle_cnt;

  logic [OW-1:0]   next_owner;
  logic            any_req;
  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            xfer;
  logic            burst_end;
  logic            timeout;

  // Round-robin pick: first valid requester after the last owner, wrapping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    next_owner = '0;
    any_req    = 1'b0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      if (!any_req && bus.req_valid[(int'(last_owner) + i) % REQUESTERS]) begin
        any_req    = 1'b1;
        next_owner = OW'((int'(last_owner) + i) % REQUESTERS);
      end
    end
  end

  // Owner's stream and the release conditions evaluated this cycle.
  always_comb begin
    own_valid = bus.req_valid[owner];
    own_last  = bus.req_last[owner];
    own_data  = bus.req_data[{owner, 3'b000} +: 8];
    xfer      = (state == TRANSFER) && own_valid && bus.tx_ready;
    burst_end = (burst_cnt + 8'd1) == 8'(MAX_BURST);
    timeout   = !own_valid && (idle_cnt == 8'(IDLE_TIMEOUT));
  end

  // Combinational passthrough of the owner's stream while in TRANSFER; quiet in IDLE.
  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    if (state == TRANSFER) begin
      bus.tx_valid         = own_valid;
      bus.tx_data          = own_data;
      bus.req_ready[owner] = bus.tx_ready;
    end
  end

  // Grant FSM: arbitrate in IDLE, hold the owner in TRANSFER until a release condition.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      owner      <= '0;
      last_owner <= OW'(REQUESTERS - 1);
      burst_cnt  <= '0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && any_req) begin
            state     <= TRANSFER;
            owner     <= next_owner;
            grant     <= {{(REQUESTERS-1){1'b0}}, 1'b1} << next_owner;
            busy      <= 1'b1;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        TRANSFER: begin
          if (xfer) begin
            // A byte moving wins over an expiring idle counter.
            burst_cnt <= burst_cnt + 8'd1;
            idle_cnt  <= '0;
            if (own_last || burst_end) begin
              state      <= IDLE;
              grant      <= '0;
              busy       <= 1'b0;
              last_owner <= owner;
            end
          end else if (!own_valid) begin
            if (timeout) begin
              state      <= IDLE;
              grant      <= '0;
              busy       <= 1'b0;
              last_owner <= owner;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end else begin
            // Owner is presenting a byte but the UART is stalled: not idle.
            idle_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
